// File: rtl/frame_egress_scheduler_pkg.sv
// Shared types and sideband field layout for the frame egress scheduler.
// The sideband writer packs its words against the same offsets.
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 8
`endif

package frame_egress_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } egress_state_t;

  // Sideband word: {end_ptr (with wrap bit), dest}
  localparam int SB_DEST_LSB = 0;
  localparam int SB_PTR_LSB  = `AXIS_DEST_WIDTH;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_WIDTH = 9;

endpackage

// File: rtl/egress_skid_buffer.sv
// Two-entry egress buffer with fall-through when empty, so a byte arriving
// from the frame buffer can leave on the same cycle it becomes valid.
module egress_skid_buffer
  import frame_egress_scheduler_pkg::*;
#(
  parameter int WIDTH = SKID_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_wr_idx;
  logic             r_rd_idx;
  logic [1:0]       r_count;

  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty     = (r_count == 2'd0);
  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = ~w_empty | i_in_valid;
  assign o_out_data  = w_empty ? i_in_data : r_mem[r_rd_idx];
  assign o_count     = r_count;

  // An arriving byte is stored only if it was not consumed straight through.
  assign w_bypass = w_empty & i_in_valid & i_out_ready;
  assign w_push   = i_in_valid & o_in_ready & ~w_bypass;
  assign w_pop    = ~w_empty & i_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 2'd0;
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
    end else begin
      if (w_push) r_wr_idx <= ~r_wr_idx;
      if (w_pop)  r_rd_idx <= ~r_rd_idx;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; occupancy lives in r_count,
  // so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_idx] <= i_in_data;
  end

endmodule

// File: rtl/frame_egress_scheduler.sv
// Pops one frame descriptor at a time, reads its bytes from the frame buffer
// and streams them out as an AXI-Stream frame tagged with the descriptor dest.
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 8
`endif

module frame_egress_scheduler
  import frame_egress_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DEST_WIDTH = `AXIS_DEST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sb_empty,
  output logic                  sb_ren,
  input  logic [19:0]           sb_rdata,
  output logic                  fb_ren,
  output logic [ADDR_WIDTH-1:0] fb_raddr,
  input  logic [7:0]            fb_rdata,
  output logic [ADDR_WIDTH:0]   fb_rptr,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [DEST_WIDTH-1:0] m_tdest
);

  localparam int PW = ADDR_WIDTH + 1;

  egress_state_t         r_state;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_end_ptr;
  logic [DEST_WIDTH-1:0] r_dest;
  logic                  r_sb_ren;
  logic                  r_rd_valid;
  logic                  r_rd_last;

  logic [PW-1:0]         w_sb_end_ptr;
  logic [DEST_WIDTH-1:0] w_sb_dest;
  logic                  w_is_last;
  logic [1:0]            w_skid_count;
  logic [1:0]            w_occ;
  logic                  w_skid_in_ready;
  logic                  w_space;
  logic                  w_fb_ren;
  logic                  w_skid_out_valid;
  logic [8:0]            w_skid_out_data;
  logic                  w_last_done;

  assign w_sb_dest    = sb_rdata[SB_DEST_LSB +: DEST_WIDTH];
  assign w_sb_end_ptr = sb_rdata[SB_PTR_LSB +: PW];

  // Full-width compare so a frame ending just past the wrap is still found.
  assign w_is_last = (r_rptr == r_end_ptr - 1'b1);

  // A read is issued only if its byte is guaranteed a buffer slot on arrival.
  assign w_occ    = w_skid_count + {1'b0, r_rd_valid};
  assign w_space  = (w_occ < 2'd2) & w_skid_in_ready;
  assign w_fb_ren = (r_state == STREAM) & w_space;

  assign w_last_done = w_skid_out_valid & m_tready & w_skid_out_data[8];

  // NOTE: all state here is sequential and updated with <= only, so every
  // branch sees the values from the start of the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rptr     <= '0;
      r_end_ptr  <= '0;
      r_dest     <= '0;
      r_sb_ren   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_sb_ren   <= 1'b0;
      r_rd_valid <= w_fb_ren;
      r_rd_last  <= w_fb_ren & w_is_last;
      if (w_fb_ren) r_rptr <= r_rptr + 1'b1;

      case (r_state)
        IDLE: begin
          if (!sb_empty) begin
            r_state  <= POP;
            r_sb_ren <= 1'b1;
          end
        end
        POP: r_state <= LOAD;
        LOAD: begin
          r_end_ptr <= w_sb_end_ptr;
          r_dest    <= w_sb_dest;
          r_state   <= (w_sb_end_ptr != r_rptr) ? STREAM : IDLE;
        end
        STREAM: begin
          if (w_fb_ren && w_is_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_last_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  egress_skid_buffer #(
    .WIDTH(SKID_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_in_valid (r_rd_valid),
    .o_in_ready (w_skid_in_ready),
    .i_in_data  ({r_rd_last, fb_rdata}),
    .o_out_valid(w_skid_out_valid),
    .i_out_ready(m_tready),
    .o_out_data (w_skid_out_data),
    .o_count    (w_skid_count)
  );

  assign sb_ren   = r_sb_ren & ~reset;
  assign fb_ren   = w_fb_ren;
  assign fb_raddr = r_rptr[ADDR_WIDTH-1:0];
  assign fb_rptr  = r_rptr;
  assign m_tvalid = w_skid_out_valid;
  assign m_tdata  = w_skid_out_data[7:0];
  assign m_tlast  = w_skid_out_data[8];
  assign m_tdest  = r_dest;

`ifdef ASSERT
  a_sb_ren_not_empty: assert property (@(posedge clk) disable iff (reset)
    sb_ren |-> !sb_empty);
  a_fb_ren_in_stream: assert property (@(posedge clk) disable iff (reset)
    fb_ren |-> (r_state == STREAM));
  a_beat_held: assert property (@(posedge clk) disable iff (reset)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata)));
`endif

endmodule

// File: tb/tb_frame_egress_scheduler.sv
// Directed bench for frame_egress_scheduler: behavioural sideband FIFO and
// frame-buffer RAM, one task per scenario with inline expected values.
module tb_frame_egress_scheduler;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sb_empty;
  logic          sb_ren;
  logic [19:0]   sb_rdata = '0;
  logic          fb_ren;
  logic [AW-1:0] fb_raddr;
  logic [7:0]    fb_rdata = '0;
  logic [PW-1:0] fb_rptr;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [DW-1:0] m_tdest;

  int errors = 0;
  int checks = 0;

  logic [19:0] sb_q[$];

  logic [7:0]    got_data[$];
  logic          got_last[$];
  logic [DW-1:0] got_dest[$];
  int            raddr_log[$];
  int            ren_cyc[$];
  int            sbren_cnt;
  int            first_valid;
  int            stall_changes;
  bit            timed_out;

  frame_egress_scheduler #(
    .ADDR_WIDTH(AW),
    .DEST_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sb_empty(sb_empty),
    .sb_ren  (sb_ren),
    .sb_rdata(sb_rdata),
    .fb_ren  (fb_ren),
    .fb_raddr(fb_raddr),
    .fb_rdata(fb_rdata),
    .fb_rptr (fb_rptr),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .m_tdest (m_tdest)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fb_byte(input int a);
    return 8'((a * 7) + 17);
  endfunction

  function automatic logic [19:0] sb_word(input int dest, input int end_ptr);
    return {12'(end_ptr), 8'(dest)};
  endfunction

  assign sb_empty = (sb_q.size() == 0);

  always @(posedge clk) begin
    if (fb_ren) fb_rdata <= fb_byte(int'(fb_raddr));
    if (sb_ren && sb_q.size() > 0) sb_rdata <= sb_q.pop_front();
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs cycles until n_frames tlast handshakes or the budget expires,
  // logging beats, reads and pops. mode 0: tready high; mode 1: 1,0,0,1.
  task automatic run_frames(input int n_frames, input int mode, input int budget);
    int         lasts = 0;
    int         cyc = 0;
    bit         done = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    got_data.delete(); got_last.delete(); got_dest.delete();
    raddr_log.delete(); ren_cyc.delete();
    sbren_cnt = 0; first_valid = -1; stall_changes = 0; timed_out = 0;
    while (!done) begin
      m_tready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (sb_ren) sbren_cnt++;
      if (fb_ren) begin
        raddr_log.push_back(int'(fb_raddr));
        ren_cyc.push_back(cyc);
      end
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stall_changes++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (m_tvalid && m_tready) begin
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
        got_dest.push_back(m_tdest);
        if (m_tlast) lasts++;
      end
      if (lasts == n_frames) done = 1;
      else if (cyc == budget) begin
        timed_out = 1;
        done = 1;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (sb_ren !== 1'b0) begin errors++; $display("FAIL reset_sb_ren: got %b want 0", sb_ren); end
    checks++; if (fb_ren !== 1'b0) begin errors++; $display("FAIL reset_fb_ren: got %b want 0", fb_ren); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    checks++; if (m_tdest !== 8'd0) begin errors++; $display("FAIL reset_tdest: got %h want 00", m_tdest); end
    checks++; if (fb_rptr !== 12'd0) begin errors++; $display("FAIL reset_rptr: got %0d want 0", fb_rptr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame;
    sb_q.push_back(sb_word(3, 5));
    run_frames(1, 0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got timeout want tlast"); end
    checks++; if (first_valid != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", first_valid); end
    checks++; if (sbren_cnt != 1) begin errors++; $display("FAIL single_sbren: got %0d want 1", sbren_cnt); end
    checks++; if (got_data.size() != 5) begin errors++; $display("FAIL single_count: got %0d want 5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_data.size()) begin
        errors++; $display("FAIL single_beat%0d: got none want %h", i, fb_byte(i));
      end else if ({got_data[i], got_last[i], got_dest[i]} !== {fb_byte(i), (i == 4), 8'd3}) begin
        errors++;
        $display("FAIL single_beat%0d: got %h/%b/%h want %h/%b/03", i, got_data[i], got_last[i], got_dest[i], fb_byte(i), (i == 4));
      end
    end
    checks++; if (fb_rptr !== 12'd5) begin errors++; $display("FAIL single_rptr: got %0d want 5", fb_rptr); end
  endtask

  task automatic test_backpressure;
    sb_q.push_back(sb_word(7, 13));
    run_frames(1, 1, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got timeout want tlast"); end
    checks++; if (got_data.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_data.size()) begin
        errors++; $display("FAIL bp_beat%0d: got none want %h", i, fb_byte(5 + i));
      end else if ({got_data[i], got_last[i], got_dest[i]} !== {fb_byte(5 + i), (i == 7), 8'd7}) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h/%b/%h want %h/%b/07", i, got_data[i], got_last[i], got_dest[i], fb_byte(5 + i), (i == 7));
      end
    end
    checks++; if (stall_changes != 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", stall_changes); end
    checks++; if (fb_rptr !== 12'd13) begin errors++; $display("FAIL bp_rptr: got %0d want 13", fb_rptr); end
  endtask

  task automatic test_zero_then_two;
    sb_q.push_back(sb_word(1, 13));
    sb_q.push_back(sb_word(2, 15));
    run_frames(1, 0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: got timeout want tlast"); end
    checks++; if (sbren_cnt != 2) begin errors++; $display("FAIL zero_sbren: got %0d want 2", sbren_cnt); end
    checks++; if (raddr_log.size() != 2) begin errors++; $display("FAIL zero_reads: got %0d want 2", raddr_log.size()); end
    checks++; if (got_data.size() != 2) begin errors++; $display("FAIL zero_count: got %0d want 2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size()) begin
        errors++; $display("FAIL zero_beat%0d: got none want %h", i, fb_byte(13 + i));
      end else if ({got_data[i], got_last[i], got_dest[i]} !== {fb_byte(13 + i), (i == 1), 8'd2}) begin
        errors++;
        $display("FAIL zero_beat%0d: got %h/%b/%h want %h/%b/02", i, got_data[i], got_last[i], got_dest[i], fb_byte(13 + i), (i == 1));
      end
    end
    checks++; if (fb_rptr !== 12'd15) begin errors++; $display("FAIL zero_rptr: got %0d want 15", fb_rptr); end
  endtask

  task automatic test_wrap;
    int exp_addr[4] = '{2046, 2047, 0, 1};
    int exp_byte_addr;
    sb_q.push_back(sb_word(4, 2046));
    run_frames(1, 0, 2200);
    checks++; if (timed_out) begin errors++; $display("FAIL fill_timeout: got timeout want tlast"); end
    checks++; if (got_data.size() != 2031) begin errors++; $display("FAIL fill_count: got %0d want 2031", got_data.size()); end
    checks++; if (fb_rptr !== 12'd2046) begin errors++; $display("FAIL fill_rptr: got %0d want 2046", fb_rptr); end

    sb_q.push_back(sb_word(5, 2050));
    run_frames(1, 0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout: got timeout want tlast"); end
    checks++; if (raddr_log.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d want 4", raddr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= raddr_log.size()) begin
        errors++; $display("FAIL wrap_raddr%0d: got none want %0d", i, exp_addr[i]);
      end else if (raddr_log[i] != exp_addr[i]) begin
        errors++; $display("FAIL wrap_raddr%0d: got %0d want %0d", i, raddr_log[i], exp_addr[i]);
      end
    end
    if (ren_cyc.size() == 4) begin
      checks++;
      if (ren_cyc[3] - ren_cyc[0] != 3) begin
        errors++; $display("FAIL wrap_contiguous: got span %0d want 3", ren_cyc[3] - ren_cyc[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_byte_addr = exp_addr[i];
      checks++;
      if (i >= got_data.size()) begin
        errors++; $display("FAIL wrap_beat%0d: got none want %h", i, fb_byte(exp_byte_addr));
      end else if ({got_data[i], got_last[i], got_dest[i]} !== {fb_byte(exp_byte_addr), (i == 3), 8'd5}) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h/%b/%h want %h/%b/05", i, got_data[i], got_last[i], got_dest[i], fb_byte(exp_byte_addr), (i == 3));
      end
    end
    checks++; if (fb_rptr !== 12'd2050) begin errors++; $display("FAIL wrap_rptr: got %0d want 2050", fb_rptr); end
  endtask

  task automatic test_reset_midframe;
    int beats = 0;
    int cyc = 0;
    bit saw_last = 0;
    sb_q.push_back(sb_word(6, 2060));
    m_tready = 1'b1;
    while (beats < 3 && cyc < 40) begin
      #1;
      if (m_tvalid && m_tready) begin
        beats++;
        if (m_tlast) saw_last = 1;
      end
      if (beats < 3) begin
        tick();
        cyc++;
      end
    end
    checks++; if (beats != 3) begin errors++; $display("FAIL midrst_beats: got %0d want 3", beats); end
    checks++; if (saw_last) begin errors++; $display("FAIL midrst_early_last: got tlast want none"); end
    reset = 1'b1;
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", m_tvalid); end
    checks++; if (fb_rptr !== 12'd0) begin errors++; $display("FAIL midrst_rptr: got %0d want 0", fb_rptr); end
    sb_q.delete();
    sb_q.push_back(sb_word(9, 3));
    tick();
    checks++; if (sb_ren !== 1'b0) begin errors++; $display("FAIL midrst_sbren_in_reset: got %b want 0", sb_ren); end
    reset = 1'b0;
    #1;
    checks++; if (sb_ren !== 1'b0) begin errors++; $display("FAIL midrst_sbren_after: got %b want 0", sb_ren); end
    run_frames(1, 0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL postrst_timeout: got timeout want tlast"); end
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL postrst_count: got %0d want 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_data.size()) begin
        errors++; $display("FAIL postrst_beat%0d: got none want %h", i, fb_byte(i));
      end else if ({got_data[i], got_last[i], got_dest[i]} !== {fb_byte(i), (i == 2), 8'd9}) begin
        errors++;
        $display("FAIL postrst_beat%0d: got %h/%b/%h want %h/%b/09", i, got_data[i], got_last[i], got_dest[i], fb_byte(i), (i == 2));
      end
    end
    checks++; if (fb_rptr !== 12'd3) begin errors++; $display("FAIL postrst_rptr: got %0d want 3", fb_rptr); end
  endtask

  initial begin
    reset    = 1'b1;
    m_tready = 1'b1;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_zero_then_two();
    test_wrap();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
